fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage for the pipelined MIPS core. It owns the PC, issues requests to instruction memory over a req/ready handshake, and presents {pc_IF, pcPlus4_IF, instr_IF, instr_valid} to the IF/ID register. It honours hold requests from the hazard unit with a one-entry skid buffer, and redirect requests from branch/jump resolution.

## Interface

- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0000, bubble encoding (sll $0,$0,0)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- hold  in  1  hazard unit: IF/ID will not load this cycle; freeze outputs
- redirect  in  1  taken branch/jump; flush fetch stream
- redirect_pc  in  32  new fetch address, valid with redirect
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word aligned
- imem_ready  in  1  imem_rdata valid this cycle; completes request
- imem_rdata  in  32  instruction word
- pc_IF  out  32  address of instr_IF
- pcPlus4_IF  out  32  pc_IF + 4
- instr_IF  out  32  fetched instruction or NOP_INSTR
- instr_valid  out  1  instr_IF is a real instruction

## Operation

- Registers: pc, state, skid {instr, pc}, target_q, and the output registers.
- Memory protocol: once imem_req=1, imem_req and imem_addr stay stable until a cycle with imem_ready=1. Zero-wait memory (ready in the same cycle as req) is legal.
- imem_req is forced to 0 while rst=1.
- States:
  - REQ: imem_req=1, imem_addr=pc.
    - ready & redirect: drop data; pc<=redirect_pc; outputs<=bubble; stay REQ.
    - ready & hold: skid<={rdata,pc}; pc<=pc+4; outputs unchanged; go FULL.
    - ready & neither: outputs<={pc, pc+4, rdata, valid=1}; pc<=pc+4.
    - !ready & redirect: target_q<=redirect_pc; outputs<=bubble; go DRAIN.
    - !ready & !hold: outputs<=bubble.
    - !ready & hold: outputs unchanged.
  - FULL: imem_req=0.
    - redirect: discard skid; pc<=redirect_pc; outputs<=bubble; go REQ.
    - !hold: outputs<=skid with valid=1; go REQ.
    - else: stay.
  - DRAIN: imem_req=1, imem_addr=pc (old address kept stable).
    - Further redirect overwrites target_q.
    - On ready: discard data; pc<=target_q (or redirect_pc if redirect is asserted that same cycle); go REQ.
    - Outputs stay bubble.
- Bubble: instr_IF=NOP_INSTR, instr_valid=0; pc_IF and pcPlus4_IF keep their previous values.
- Priority: rst > redirect > hold.
- Arithmetic: pc+4 is 32-bit and wraps from 32'hFFFF_FFFC to 0. redirect_pc[1:0] is ignored (forced to 0).

## Timing

- Reset values: state=REQ, pc=RESET_PC, pc_IF=0, pcPlus4_IF=0, instr_IF=NOP_INSTR, instr_valid=0, skid=0, target_q=0.
- First cycle after rst drops: imem_req=1, imem_addr=RESET_PC.
- Latency: instruction visible on outputs the edge after the ready cycle.
- Throughput: 1 instruction/cycle with ready tied high.
- Redirect with ready in cycle n: request to target in n+1; target instruction valid after edge n+1. Exactly one bubble cycle (n+1).
- Hold asserted with ready in the same cycle: the word is parked in skid, and the first cycle with hold=0 presents it, giving no loss and no duplication.
- Hold for k cycles in FULL: no requests issued.
- Reset mid-request: the request is abandoned; the memory model is reset by the same rst.

## Structure

- Shared header mips_defs.vh: NOP_INSTR constant, fetch state encodings (REQ, FULL, DRAIN, 2 bits).
- No sub-module: the skid register and FSM are small and tightly coupled, so they stay inline in fetch_unit.

## Test plan

- Reset, ready tied 1, RESET_PC=0: instr_IF sequence for addresses 0,4,8… appears one per cycle, with pcPlus4_IF=pc_IF+4 and instr_valid=1 from the second cycle onward.
- Ready low for 3 cycles at addr 0x10: imem_addr is held at 0x10 and imem_req stays 1; 3 bubble cycles; then instr@0x10 is valid.
- hold=1 in the same cycle as ready at 0x20, held for 2 cycles: outputs frozen, imem_req=0; after release, instr@0x20 then instr@0x24, each appearing exactly once.
- redirect to 0x100 while ready=0 (DRAIN), memory returns 2 cycles later: stale word never reaches instr_IF, and the next request address is 0x100.
- redirect to 0x200 together with hold in FULL: skid discarded, one bubble, then instr@0x200 with pc_IF=0x200.
- pc=0xFFFF_FFFC fetched: pcPlus4_IF=0 and the next imem_addr=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: bubble encoding, reset PC and FSM state encoding.
package fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        StReq   = 2'd0,
        StFull  = 2'd1,
        StDrain = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ready handshake and feeds IF/ID,
// with a one-entry skid buffer for hazard holds and a drain state for in-flight redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_IF,
    output logic [31:0] pcPlus4_IF,
    output logic [31:0] instr_IF,
    output logic        instr_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  skid_instr_q, skid_instr_d;
    logic [31:0]  skid_pc_q, skid_pc_d;
    logic [31:0]  target_q, target_d;
    logic [31:0]  pc_if_q, pc_if_d;
    logic [31:0]  pc_plus4_q, pc_plus4_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;

    logic [31:0] redirect_pc_al;
    logic [31:0] pc_inc;

    assign redirect_pc_al = align_pc(redirect_pc);
    assign pc_inc         = pc_q + PC_STEP;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        target_d     = target_q;
        pc_if_d      = pc_if_q;
        pc_plus4_d   = pc_plus4_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        imem_req     = 1'b0;
        imem_addr    = pc_q;

        unique case (state_q)
            StReq: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    if (redirect) begin
                        pc_d    = redirect_pc_al;
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end else if (hold) begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_q;
                        pc_d         = pc_inc;
                        state_d      = StFull;
                    end else begin
                        pc_if_d    = pc_q;
                        pc_plus4_d = pc_inc;
                        instr_d    = imem_rdata;
                        valid_d    = 1'b1;
                        pc_d       = pc_inc;
                    end
                end else if (redirect) begin
                    // Request still in flight: it must complete before the new address can go out.
                    target_d = redirect_pc_al;
                    instr_d  = NOP_INSTR;
                    valid_d  = 1'b0;
                    state_d  = StDrain;
                end else if (!hold) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end
            StFull: begin
                if (redirect) begin
                    pc_d    = redirect_pc_al;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    state_d = StReq;
                end else if (!hold) begin
                    pc_if_d    = skid_pc_q;
                    pc_plus4_d = skid_pc_q + PC_STEP;
                    instr_d    = skid_instr_q;
                    valid_d    = 1'b1;
                    state_d    = StReq;
                end
            end
            StDrain: begin
                imem_req = 1'b1;
                instr_d  = NOP_INSTR;
                valid_d  = 1'b0;
                if (redirect) begin
                    target_d = redirect_pc_al;
                end
                if (imem_ready) begin
                    pc_d    = redirect ? redirect_pc_al : target_q;
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StReq;
            end
        endcase

        if (rst) begin
            imem_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StReq;
            pc_q         <= RESET_PC;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            target_q     <= 32'h0;
            pc_if_q      <= 32'h0;
            pc_plus4_q   <= 32'h0;
            instr_q      <= NOP_INSTR;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            target_q     <= target_d;
            pc_if_q      <= pc_if_d;
            pc_plus4_q   <= pc_plus4_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
        end
    end

    assign pc_IF       = pc_if_q;
    assign pcPlus4_IF  = pc_plus4_q;
    assign instr_IF    = instr_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random hold/redirect/ready traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_IF;
    logic [31:0] pcPlus4_IF;
    logic [31:0] instr_IF;
    logic        instr_valid;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Memory answers whatever address is on the bus; garbage when not ready.
    assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .pc_IF       (pc_IF),
        .pcPlus4_IF  (pcPlus4_IF),
        .instr_IF    (instr_IF),
        .instr_valid (instr_valid)
    );

    // Reference model: next fetch address, pending redirect target, parked words, IF/ID view.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } park_t;

    logic [31:0] m_fetch_pc;
    logic        m_draining;
    logic [31:0] m_target;
    park_t       m_parked[$];
    logic [31:0] m_pc_if;
    logic [31:0] m_pc4;
    logic [31:0] m_instr;
    logic        m_valid;
    bit          m_known = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fetch_pc = DEFAULT_RESET_PC;
        m_draining = 1'b0;
        m_target   = 32'h0;
        m_parked.delete();
        m_pc_if    = 32'h0;
        m_pc4      = 32'h0;
        m_instr    = NOP_INSTR;
        m_valid    = 1'b0;
        m_known    = 1'b1;
    endtask

    task automatic bubble();
        m_instr = NOP_INSTR;
        m_valid = 1'b0;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] instr);
        m_pc_if = pc;
        m_pc4   = pc + 32'd4;
        m_instr = instr;
        m_valid = 1'b1;
    endtask

    // Applies one clock edge to the model using the inputs held across that edge.
    task automatic model_step();
        logic [31:0] rpc;
        park_t       p;
        rpc = redirect_pc & 32'hFFFF_FFFC;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_parked.size() != 0) begin
            if (redirect) begin
                m_parked.delete();
                m_fetch_pc = rpc;
                bubble();
            end else if (!hold) begin
                p = m_parked.pop_front();
                present(p.pc, p.instr);
            end
            return;
        end
        if (redirect) begin
            bubble();
            if (imem_ready) begin
                m_fetch_pc = rpc;
                m_draining = 1'b0;
            end else begin
                m_draining = 1'b1;
                m_target   = rpc;
            end
        end else if (m_draining) begin
            bubble();
            if (imem_ready) begin
                m_fetch_pc = m_target;
                m_draining = 1'b0;
            end
        end else if (imem_ready) begin
            p.pc    = m_fetch_pc;
            p.instr = mem_word(m_fetch_pc);
            if (hold) m_parked.push_back(p);
            else present(p.pc, p.instr);
            m_fetch_pc = m_fetch_pc + 32'd4;
        end else if (!hold) begin
            bubble();
        end
    endtask

    task automatic check_all();
        logic exp_req;
        exp_req = !rst && (m_parked.size() == 0);
        check_eq("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check_eq("imem_addr", imem_addr, m_fetch_pc);
        check_eq("pc_IF", pc_IF, m_pc_if);
        check_eq("pcPlus4_IF", pcPlus4_IF, m_pc4);
        check_eq("instr_IF", instr_IF, m_instr);
        check_eq("instr_valid", 32'(instr_valid), 32'(m_valid));
    endtask

    task automatic run_cycle(input logic r, input logic h, input logic rd,
                             input logic [31:0] rpc, input logic rdy);
        rst         = r;
        hold        = h;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ready  = rdy;
        #1;
        if (m_known) check_all();
        else check_eq("imem_req_in_reset", 32'(imem_req), 32'(1'b0));
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        // Reset
        run_cycle(1, 0, 0, 32'h0, 1);
        run_cycle(1, 0, 0, 32'h0, 1);
        // Streaming with ready tied high: 0x0..0xC
        for (int i = 0; i < 4; i++) run_cycle(0, 0, 0, 32'h0, 1);
        // Wait states at 0x10
        for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) run_cycle(0, 0, 0, 32'h0, 1);
        // Hold with ready at 0x20, held 2 cycles, then release
        run_cycle(0, 1, 0, 32'h0, 1);
        run_cycle(0, 1, 0, 32'h0, 1);
        run_cycle(0, 1, 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 32'h0, 1);
        // Redirect to 0x100 while the request is stalled; memory answers 2 cycles later
        run_cycle(0, 0, 1, 32'h0000_0100, 0);
        run_cycle(0, 0, 0, 32'h0, 0);
        run_cycle(0, 0, 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 32'h0, 1);
        // Park a word, then redirect to 0x200 together with hold
        run_cycle(0, 1, 0, 32'h0, 1);
        run_cycle(0, 1, 1, 32'h0000_0203, 1);
        for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 32'h0, 1);
        // PC wrap at the top of the address space
        run_cycle(0, 0, 1, 32'hFFFF_FFF8, 1);
        for (int i = 0; i < 4; i++) run_cycle(0, 0, 0, 32'h0, 1);
        // Random traffic, including occasional mid-request resets
        for (int i = 0; i < 4000; i++) begin
            run_cycle(($urandom_range(0, 199) == 0),
                      ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 9) == 0),
                      $urandom(),
                      ($urandom_range(0, 3) != 0));
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
